// File: rtl/inout_bus_arbiter_if.sv
// Requester-side handshake bundle for the shared inout net arbiter.
// The arbiter takes the slave modport; requester logic takes the master modport.
interface inout_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   wr;
  logic [NREQ*W-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      rdata;
  logic              oe;
  logic              conflict;

  modport master (
    output req, wr, wdata,
    input  gnt, done, rdata, oe, conflict
  );

  modport slave (
    input  req, wr, wdata,
    output gnt, done, rdata, oe, conflict
  );
endinterface

// File: rtl/inout_bus_arbiter.sv
// Round-robin arbiter and turnaround sequencer for one shared inout net.
// It is the only on-chip driver of io; every phase is followed by a released gap.
module inout_bus_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int HOLD = 2,
  parameter int TA   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inout_bus_arbiter_if.slave   bus,
  inout  wire [W-1:0]          io
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (HOLD > TA) ? HOLD : TA;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD - 1);
  localparam logic [CNTW-1:0] TA_LAST   = CNTW'((TA > 0) ? TA - 1 : 0);
  localparam logic [IDXW-1:0] IDX_MAX   = IDXW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    TURN
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    data_q, data_d;
  logic [W-1:0]    rdata_q;
  logic            conflict_q;

  logic [IDXW-1:0] sel;
  logic            found;
  logic            phase_last;
  logic            turn_last;
  logic            oe;

  assign phase_last = (cnt_q == HOLD_LAST);
  assign turn_last  = (cnt_q == TA_LAST);

  // Rotating priority search starting at ptr; first set req bit wins.
  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : pick
    int pos;
    found = 1'b0;
    sel   = ptr_q;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req[IDXW'(pos)]) begin
        found = 1'b1;
        sel   = IDXW'(pos);
      end
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    data_d   = data_q;
    bus.gnt  = '0;
    bus.done = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          // wr and wdata matter only here; later changes are ignored.
          idx_d   = sel;
          data_d  = bus.wdata[sel*W +: W];
          ptr_d   = (sel == IDX_MAX) ? '0 : sel + 1'b1;
          cnt_d   = '0;
          state_d = bus.wr[sel] ? DRIVE : SAMPLE;
        end
      end

      DRIVE, SAMPLE: begin
        bus.gnt[idx_q] = 1'b1;
        if (phase_last) begin
          bus.done[idx_q] = 1'b1;
          cnt_d           = '0;
          state_d         = (TA > 0) ? TURN : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      TURN: begin
        if (turn_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // NOTE: !== makes X or Z on the net count as contention, not just a wrong 0/1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (state_q == SAMPLE && phase_last) begin
        rdata_q <= io;
      end
      if (state_q == DRIVE && io !== data_q) begin
        conflict_q <= 1'b1;
      end
    end
  end

  // Driver enable comes straight from the state register so reset releases the net immediately.
  assign oe           = (state_q == DRIVE);
  assign io           = oe ? data_q : {W{1'bz}};
  assign bus.oe       = oe;
  assign bus.rdata    = rdata_q;
  assign bus.conflict = conflict_q;

  gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.gnt));
  done_in_gnt: assert property (@(posedge clk) disable iff (!rst_n) (bus.done & ~bus.gnt) == '0);

endmodule

// File: tb/tb_inout_bus_arbiter.sv
// Directed self-checking bench for inout_bus_arbiter at NREQ=4, W=8, HOLD=2, TA=1.
module tb_inout_bus_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wire  [W-1:0] io;
  logic [W-1:0] drv_val;
  logic         drv_en;
  assign io = drv_en ? drv_val : {W{1'bz}};

  inout_bus_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  inout_bus_arbiter #(.NREQ(NREQ), .W(W), .HOLD(2), .TA(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .io    (io)
  );

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wdata(input int i, input logic [W-1:0] v);
    bus.wdata[i*W +: W] = v;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.wr = '0; bus.wdata = '0;
    drv_en = 1'b0; drv_val = '0;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", bus.gnt, 4'b0000); end
    checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected %b", bus.done, 4'b0000); end
    checks++; if (bus.oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", bus.oe); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", bus.rdata); end
    checks++; if (bus.conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b expected 0", bus.conflict); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    bus.wr[2] = 1'b1;
    set_wdata(2, 8'hA5);
    bus.req[2] = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL write_gnt: got %b expected %b", bus.gnt, 4'b0100); end
    checks++; if (bus.oe !== 1'b1) begin errors++; $display("FAIL write_oe: got %b expected 1", bus.oe); end
    checks++; if (io !== 8'hA5) begin errors++; $display("FAIL write_io1: got %h expected a5", io); end
    checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL write_done_early: got %b expected %b", bus.done, 4'b0000); end
    tick();
    checks++; if (bus.done !== 4'b0100) begin errors++; $display("FAIL write_done: got %b expected %b", bus.done, 4'b0100); end
    checks++; if (io !== 8'hA5) begin errors++; $display("FAIL write_io2: got %h expected a5", io); end
    bus.req[2] = 1'b0;
    tick();
    checks++; if (bus.oe !== 1'b0 || bus.gnt !== 4'b0000) begin errors++; $display("FAIL write_turn: got oe=%b gnt=%b expected oe=0 gnt=0000", bus.oe, bus.gnt); end
    tick();
    checks++; if (bus.conflict !== 1'b0) begin errors++; $display("FAIL write_conflict: got %b expected 0", bus.conflict); end
  endtask

  task automatic test_single_read();
    drv_val = 8'h3C; drv_en = 1'b1;
    bus.wr[1] = 1'b0;
    bus.req[1] = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL read_gnt: got %b expected %b", bus.gnt, 4'b0010); end
    checks++; if (bus.oe !== 1'b0) begin errors++; $display("FAIL read_oe: got %b expected 0", bus.oe); end
    tick();
    checks++; if (bus.done !== 4'b0010) begin errors++; $display("FAIL read_done: got %b expected %b", bus.done, 4'b0010); end
    bus.req[1] = 1'b0;
    tick();
    checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL read_rdata: got %h expected 3c", bus.rdata); end
    drv_en = 1'b0; drv_val = 8'h00;
    tick(); tick();
    checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL read_rdata_hold: got %h expected 3c", bus.rdata); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    bus.wr = 4'b1111;
    for (int k = 0; k < NREQ; k++) set_wdata(k, 8'((k + 1) * 8'h11));
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      exp_d = 8'(((g % 4) + 1) * 8'h11);
      tick();
      checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", g, bus.gnt, exp_g); end
      checks++; if (io !== exp_d) begin errors++; $display("FAIL rr_io[%0d]: got %h expected %h", g, io, exp_d); end
      tick();
      checks++; if (bus.done !== exp_g) begin errors++; $display("FAIL rr_done[%0d]: got %b expected %b", g, bus.done, exp_g); end
      tick();
      checks++; if (bus.gnt !== 4'b0000 || bus.oe !== 1'b0) begin errors++; $display("FAIL rr_turn[%0d]: got gnt=%b oe=%b expected gnt=0000 oe=0", g, bus.gnt, bus.oe); end
      tick();
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rr_idle[%0d]: got %b expected 0000", g, bus.gnt); end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_contention();
    // Complementary patterns differ from the write data under any driver resolution.
    set_wdata(0, 8'h0F);
    drv_val = 8'hF0; drv_en = 1'b1;
    bus.req = 4'b0001;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL cont_gnt: got %b expected %b", bus.gnt, 4'b0001); end
    tick();
    bus.req = 4'b0000;
    tick();
    drv_en = 1'b0;
    checks++; if (bus.conflict !== 1'b1) begin errors++; $display("FAIL cont_flag: got %b expected 1", bus.conflict); end
    tick();
    set_wdata(3, 8'h77);
    bus.req = 4'b1000;
    tick();
    checks++; if (bus.gnt !== 4'b1000 || io !== 8'h77) begin errors++; $display("FAIL cont_clean: got gnt=%b io=%h expected gnt=1000 io=77", bus.gnt, io); end
    tick();
    bus.req = 4'b0000;
    tick(); tick();
    checks++; if (bus.conflict !== 1'b1) begin errors++; $display("FAIL cont_sticky: got %b expected 1", bus.conflict); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.conflict !== 1'b0) begin errors++; $display("FAIL cont_clear: got %b expected 0", bus.conflict); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    bus.wr = 4'b1111;
    set_wdata(1, 8'h66);
    bus.req = 4'b0010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL ar_pre_gnt: got %b expected %b", bus.gnt, 4'b0010); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.gnt !== 4'b0000 || bus.oe !== 1'b0) begin errors++; $display("FAIL ar_immediate: got gnt=%b oe=%b expected gnt=0000 oe=0", bus.gnt, bus.oe); end
    tick();
    checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL ar_no_done: got %b expected 0000", bus.done); end
    set_wdata(0, 8'h5A);
    set_wdata(3, 8'hC3);
    bus.req = 4'b1001;
    #2 rst_n = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0001 || io !== 8'h5A) begin errors++; $display("FAIL ar_first: got gnt=%b io=%h expected gnt=0001 io=5a", bus.gnt, io); end
    tick();
    bus.req = 4'b1000;
    tick(); tick(); tick();
    checks++; if (bus.gnt !== 4'b1000 || io !== 8'hC3) begin errors++; $display("FAIL ar_second: got gnt=%b io=%h expected gnt=1000 io=c3", bus.gnt, io); end
    tick();
    bus.req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_late_request();
    set_wdata(0, 8'h99);
    bus.req = 4'b0001;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL late_gnt: got %b expected %b", bus.gnt, 4'b0001); end
    bus.req = 4'b1001;
    tick();
    checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL late_done: got %b expected %b", bus.done, 4'b0001); end
    bus.req = 4'b0000;
    tick(); tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.gnt !== 4'b0000 || bus.oe !== 1'b0) begin errors++; $display("FAIL late_idle[%0d]: got gnt=%b oe=%b expected gnt=0000 oe=0", c, bus.gnt, bus.oe); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_contention();
    test_async_reset();
    test_late_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
